// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control blocks: hazard-controller
// states, the architectural zero register, and the decoder's opcode values.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Opcodes as decoded upstream; HALT is the custom all-ones opcode.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] HALT      = 7'b1111111;

endpackage

// File: rtl/perf_counter.sv
// Enable-gated free-running counter with synchronous reset; wraps to zero
// after the all-ones value.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: advance by one when enabled; natural overflow gives the wrap.
    always_comb begin
        count_d = en_i ? count_q + W'(1) : count_q;
    end

    // Count register with synchronous clear.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, EX redirects and halt drain,
// plus cycle/stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_halt,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic       luse;
    logic       cycle_en, stall_en, flush_en;

    // A load in EX writing a register that ID reads cannot forward in time.
    assign luse = ex_mem_read && (ex_rd != REG_ZERO) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Next-state and control outputs; RUN is purely combinational from inputs.
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case/if tree can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b0;
        cycle_en    = 1'b0;
        stall_en    = 1'b0;
        flush_en    = 1'b0;

        if (reset) begin
            // Hold both pipeline registers as bubbles until reset releases.
            if_id_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    cycle_en = 1'b1;
                    if (ex_redirect) begin
                        // Wrong-path instructions in IF and ID are squashed.
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        flush_en    = 1'b1;
                    end else if (luse) begin
                        // Freeze PC and IF/ID, send a bubble into EX.
                        stall_en = 1'b1;
                    end else if (id_halt) begin
                        // Let the halt move into EX; nothing younger follows it.
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b0;
                        state_d     = ST_DRAIN;
                        dcnt_d      = DRAIN_LAST;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        id_ex_flush = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    cycle_en = 1'b1;
                    if (dcnt_q == 3'd0) begin
                        state_d = ST_HALTED;
                    end else begin
                        dcnt_d = dcnt_q - 3'd1;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and drain-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            dcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (cycle_en),
        .count_o (cycle_count)
    );

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (stall_en),
        .count_o (stall_count)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (flush_en),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for RUN-state
// hazard resolution plus hand sequences for reset, halt drain and wrap.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_halt;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_redirect;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [31:0] cycle_count, stall_count, flush_count;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_halted;
    logic [3:0]  s_cycle_count, s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_cyc, exp_stall, exp_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .id_halt     (id_halt),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .halted      (halted),
        .cycle_count (cycle_count),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    // Narrow-counter instance used for the wrap check.
    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_dut_small (
        .clk         (clk),
        .reset       (reset),
        .id_halt     (id_halt),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .pc_write    (s_pc_write),
        .if_id_write (s_if_id_write),
        .if_id_flush (s_if_id_flush),
        .id_ex_flush (s_id_ex_flush),
        .halted      (s_halted),
        .cycle_count (s_cycle_count),
        .stall_count (s_stall_count),
        .flush_count (s_flush_count)
    );

    // Control bits packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, halted}.
    localparam logic [4:0] C_IDLE   = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_REDIR  = 5'b11110;
    localparam logic [4:0] C_HALT   = 5'b01100;
    localparam logic [4:0] C_DRAIN  = 5'b00010;
    localparam logic [4:0] C_HALTED = 5'b00011;
    localparam logic [4:0] C_RESET  = 5'b00110;

    typedef struct {
        logic       redirect;
        logic       mem_read;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       halt;
        logic [4:0] exp_ctrl;
        logic       inc_stall;
        logic       inc_flush;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic redir, input logic mrd, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic hlt);
        ex_redirect = redir;
        ex_mem_read = mrd;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_halt     = hlt;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, REG_ZERO, REG_ZERO, REG_ZERO, 1'b0);
    endtask

    task automatic check_ctrl(input string name, input logic [4:0] exp);
        #1;
        check(name, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, halted}, {27'd0, exp});
    endtask

    task automatic check_cnt(input string name);
        check({name, " cycle_count"}, cycle_count, exp_cyc);
        check({name, " stall_count"}, stall_count, exp_stall);
        check({name, " flush_count"}, flush_count, exp_flush);
    endtask

    // Two reset edges, then release with idle inputs; checks outputs on both sides.
    task automatic do_reset(input string name);
        reset = 1'b1;
        idle();
        tick();
        tick();
        check_ctrl({name, " ctrl in reset"}, C_RESET);
        reset = 1'b0;
        exp_cyc   = 0;
        exp_stall = 0;
        exp_flush = 0;
        check_ctrl({name, " ctrl after release"}, C_IDLE);
        check_cnt({name, " after release"});
    endtask

    initial begin
        //                redir mrd  rd     rs1    rs2    halt  ctrl     +stl  +fls
        vecs[0] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, C_IDLE,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd5,  5'd0,  5'd5,  1'b0, C_STALL, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, C_IDLE,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'd7,  5'd7,  5'd3,  1'b0, C_STALL, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 5'd7,  5'd7,  5'd7,  1'b0, C_IDLE,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd9,  5'd8,  5'd10, 1'b0, C_IDLE,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, C_REDIR, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 5'd5,  5'd1,  5'd5,  1'b1, C_REDIR, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 5'd31, 5'd31, 5'd2,  1'b1, C_STALL, 1'b1, 1'b0};

        reset = 1'b1;
        idle();
        @(negedge clk);

        // Reset, then idle run with cycle counting; narrow counter wraps at 16.
        do_reset("init");
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp_cyc++;
            check_cnt($sformatf("idle %0d", i));
        end
        check("wrap cycle_count CNT_W=4", {28'd0, s_cycle_count}, 32'd1);

        // Table of single-cycle RUN-state hazard cases.
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].redirect, vecs[i].mem_read, vecs[i].rd,
                   vecs[i].rs1, vecs[i].rs2, vecs[i].halt);
            check_ctrl($sformatf("vec %0d ctrl", i), vecs[i].exp_ctrl);
            tick();
            exp_cyc++;
            if (vecs[i].inc_stall) exp_stall++;
            if (vecs[i].inc_flush) exp_flush++;
            check_cnt($sformatf("vec %0d", i));
        end

        // Halt drain: stall with halt at cycle 9, halt taken at cycle 10.
        do_reset("halt");
        for (int k = 0; k < 9; k++) tick();
        exp_cyc = 9;
        check_cnt("halt cycle 9");
        set_in(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1);
        check_ctrl("halt+luse stalls first", C_STALL);
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_ctrl("halt taken cycle 10", C_HALT);
        tick();
        // Redirect/luse during drain must be ignored.
        set_in(1'b1, 1'b1, 5'd6, 5'd6, 5'd6, 1'b1);
        check_ctrl("drain cycle 11", C_DRAIN);
        check("drain cycle 11 cycle_count", cycle_count, 32'd11);
        tick();
        check_ctrl("drain cycle 12", C_DRAIN);
        tick();
        idle();
        check_ctrl("drain cycle 13", C_DRAIN);
        tick();
        check_ctrl("halted cycle 14", C_HALTED);
        exp_cyc = 14; exp_stall = 1; exp_flush = 0;
        check_cnt("halted cycle 14");
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        check_ctrl("halted ignores redirect", C_HALTED);
        check_cnt("halted frozen");

        // Reset from HALTED, then reset in the second drain cycle.
        do_reset("from halted");
        tick();
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_ctrl("mid-drain halt", C_HALT);
        tick();
        idle();
        tick();
        check_ctrl("second drain cycle", C_DRAIN);
        check("second drain cycle_count", cycle_count, 32'd4);
        reset = 1'b1;
        check_ctrl("reset during drain", C_RESET);
        tick();
        reset = 1'b0;
        exp_cyc = 0; exp_stall = 0; exp_flush = 0;
        check_ctrl("run after drain reset", C_IDLE);
        check_cnt("after drain reset");
        tick();
        exp_cyc = 1;
        check_cnt("first cycle after drain reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
